// File: rtl/rsa_mult_arb_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and a constant log2 ladder.
// Pure declarations; no logic or latency of its own.
package rsa_mult_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Ceiling log2 with a floor of 1 so that single-entry counters still get a bit.
  function automatic int arb_clog2(input int v);
    if (v <= 2)          return 1;
    else if (v <= 4)     return 2;
    else if (v <= 8)     return 3;
    else if (v <= 16)    return 4;
    else if (v <= 32)    return 5;
    else if (v <= 64)    return 6;
    else if (v <= 128)   return 7;
    else if (v <= 256)   return 8;
    else if (v <= 512)   return 9;
    else if (v <= 1024)  return 10;
    else if (v <= 2048)  return 11;
    else if (v <= 4096)  return 12;
    else if (v <= 8192)  return 13;
    else if (v <= 16384) return 14;
    else if (v <= 32768) return 15;
    else if (v <= 65536) return 16;
    else                 return 32;
  endfunction

endpackage

// File: rtl/rsa_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to act on the pick.
module rsa_rr_pick
  import rsa_mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PW = arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      index
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      j = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        index  = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rsa_mult_arb.sv
// Round-robin sequencer sharing one multiplier between NUM_REQ requesters, with a done watchdog.
// Grant 1 cycle after request, response 1 cycle after done; requesters hold req_valid until rsp_valid.
module rsa_mult_arb
  import rsa_mult_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                          arb_clk,
  input  logic                          arb_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            arb_gnt,
  output logic                          arb_busy,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic                          rsp_err,
  output logic                          mult_start,
  output logic [DATA_WIDTH-1:0]         mult_a,
  output logic [DATA_WIDTH-1:0]         mult_b,
  input  logic                          mult_done,
  input  logic [2*DATA_WIDTH-1:0]       mult_c
);

  localparam int PW = arb_clog2(NUM_REQ);
  localparam int WW = arb_clog2(TIMEOUT);

  arb_state_e              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           idx_q, idx_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    err_q, err_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [PW-1:0]           pick_idx;

  rsa_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .index (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        // Operands are frozen here because the multiplier re-samples them while it initialises.
        if (|req_valid) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          a_d     = req_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          b_d     = req_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          state_d = ARB_START;
        end
      end
      ARB_START: begin
        wd_d    = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mult_done) begin
          res_d   = mult_c;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (wd_q == WW'(TIMEOUT-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ptr_d   = (idx_q == PW'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
        gnt_d   = '0;
        err_d   = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign arb_gnt    = gnt_q;
  assign arb_busy   = (state_q != ARB_IDLE);
  assign mult_start = (state_q == ARB_START);
  assign rsp_valid  = (state_q == ARB_RESP) ? gnt_q : '0;
  assign rsp_data   = (state_q == ARB_RESP) ? res_q : '0;
  assign rsp_err    = err_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;

endmodule
